fram_arbiter: RTL and testbench
===============================

Name: fram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the FRAM memory wrapper.
- The wrapper's request interface is: ready, 16-bit address, 32-bit write data, 32-bit read data, we/re strobes.
- Grants one requester at a time, alternating priority (round-robin), and issues a single-cycle we/re strobe to the wrapper.
- Tracks the busy/ready cycle, returns read data with a one-cycle ack, and aborts with an error ack if the wrapper never completes.
- Masters: m0 = CPU data port, m1 = DMA/loader port.

Parameters:
- TIMEOUT_CYCLES, 4095, maximum WAIT cycles before an error ack; must fit in CNT_W bits.
- CNT_W, 12, width of the watchdog counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- m0_req  input  1  m0 request, held high until m0_ack
- m0_we  input  1  m0 write (1) / read (0), stable while m0_req
- m0_addr  input  16  m0 word address
- m0_wdata  input  32  m0 write data
- m0_rdata  output  32  m0 read data, valid when m0_ack
- m0_ack  output  1  one-cycle completion pulse
- m0_err  output  1  qualifies m0_ack: transaction timed out
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as m0, for m1
- mem_ready  input  1  wrapper idle/done
- mem_addr  output  16  to wrapper
- mem_wdata  output  32  to wrapper
- mem_rdata  input  32  from wrapper; valid when mem_ready rises after a read
- mem_we  output  1  single-cycle write strobe
- mem_re  output  1  single-cycle read strobe
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, prio=m0, all outputs 0, counter 0, seen_busy 0, latched fields 0.
- IDLE:
  - If mem_ready=1 and any req: grant. With both requesting, the prio master wins; with one requesting, that master wins.
  - Latch grant id, we, addr, wdata; go to ISSUE.
  - If mem_ready=0, no grant.
- ISSUE (1 cycle):
  - mem_addr/mem_wdata driven from the latched fields and held stable until the next grant.
  - mem_we=latched_we, mem_re=!latched_we, both registered and high for exactly this one cycle.
  - Clear counter and seen_busy; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - seen_busy sets when mem_ready=0.
  - Normal completion: mem_ready=1 with seen_busy=1 (or seen_busy being set in the same cycle is not a completion). Capture mem_rdata into the granted master's rdata on reads only, err=0, go to ACK.
  - Timeout: counter==TIMEOUT_CYCLES-1 without completion. Set err=1, leave rdata unchanged, go to ACK.
  - Completion and timeout in the same cycle: completion wins.
- ACK (1 cycle):
  - Granted master's ack=1 and err as set; the other master's ack stays 0.
  - prio flips to the non-granted master.
  - Go to IDLE.
  - ack/err are registered and clear the next cycle.
- Latency:
  - Grant happens on the IDLE-cycle edge; strobe in the next cycle.
  - ack appears 2 cycles after mem_ready returns high (WAIT capture, then ACK).
  - Minimum req-to-ack is 5 cycles, given a wrapper that drops ready immediately and completes one cycle later.
- Request handling:
  - Back-to-back: one IDLE cycle between ack and the next grant. A master may re-assert or hold req in the ack cycle; the held req is treated as a new request.
  - Requester dropping req mid-transaction: the transaction still completes and ack still pulses.
  - req and address/data changes outside IDLE are ignored.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0 and no ack. The wrapper is reset by the same rst_n.
- m*_rdata holds its last captured value until the next successful read for that master.

Test Plan:
- m0 write addr 0x0010 data 0xDEADBEEF, then m0 read 0x0010 -> single-cycle mem_we then mem_re strobes; m0_ack twice, m0_err=0, m0_rdata=0xDEADBEEF.
- m0 and m1 assert req in the same cycle after reset -> m0 granted first, m1 next; then both again -> m0 wins once more (prio flipped back after the m1 grant); mem_addr matches each grant.
- m1 alone requesting continuously 3 times -> 3 consecutive m1 grants, each ack separated by at least 4 cycles, m0_ack never pulses.
- Wrapper model holds mem_ready=0 forever, TIMEOUT_CYCLES=16 -> exactly one ack with err=1 after 16 WAIT cycles; rdata unchanged; next request is served normally.
- rst_n pulsed low during WAIT of an m0 read -> all outputs 0 immediately, no ack; after release, a new m1 read of 0x0004 completes correctly.
- mem_ready=0 while IDLE with m0_req=1 -> no strobe issued until mem_ready=1; strobe then occurs on the following cycle.

Source files
------------

// File: rtl/fram_arbiter.sv
// Two-master round-robin arbiter and sequencer for the FRAM wrapper: one strobe per grant,
// busy/ready handshake tracking, and a watchdog that converts a stuck access into an error ack.
module fram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4095,
    parameter int unsigned CNT_W          = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic             prio_q, prio_d;      // 1: m1 wins a tie
    logic             gnt_q, gnt_d;        // 1: m1 holds the grant
    logic             we_q, we_d;
    logic [15:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seen_busy_q, seen_busy_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;
    logic             m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic             m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;

    logic             sel_m1;
    logic             sel_we;
    logic             done;
    logic             timeout;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_ack_d    = 1'b0;
        m0_err_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m1_err_d    = 1'b0;

        sel_m1  = (m0_req && m1_req) ? prio_q : m1_req;
        sel_we  = sel_m1 ? m1_we : m0_we;
        // Ready must have dropped at least once before a high counts as completion.
        done    = mem_ready && seen_busy_q;
        timeout = !done && (cnt_q == CntLast);

        unique case (state_q)
            StIdle: begin
                if (mem_ready && (m0_req || m1_req)) begin
                    gnt_d    = sel_m1;
                    we_d     = sel_we;
                    addr_d   = sel_m1 ? m1_addr : m0_addr;
                    wdata_d  = sel_m1 ? m1_wdata : m0_wdata;
                    mem_we_d = sel_we;
                    mem_re_d = !sel_we;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d       = '0;
                seen_busy_d = 1'b0;
                state_d     = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_ready) begin
                    seen_busy_d = 1'b1;
                end
                if (done || timeout) begin
                    if (done && !we_q) begin
                        if (gnt_q) begin
                            m1_rdata_d = mem_rdata;
                        end else begin
                            m0_rdata_d = mem_rdata;
                        end
                    end
                    m0_ack_d = !gnt_q;
                    m1_ack_d = gnt_q;
                    m0_err_d = !gnt_q && timeout;
                    m1_err_d = gnt_q && timeout;
                    state_d  = StAck;
                end
            end
            StAck: begin
                prio_d  = !gnt_q;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_ack_q    <= m0_ack_d;
            m0_err_q    <= m0_err_d;
            m1_ack_q    <= m1_ack_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = (state_q != StIdle);
    assign m0_rdata  = m0_rdata_q;
    assign m0_ack    = m0_ack_q;
    assign m0_err    = m0_err_q;
    assign m1_rdata  = m1_rdata_q;
    assign m1_ack    = m1_ack_q;
    assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_fram_arbiter.sv
// Bench for fram_arbiter: FRAM wrapper model, directed scenarios, random two-master traffic,
// and a cycle-indexed transaction model compared against every output on every cycle.
`timescale 1ns/1ps
module tb_fram_arbiter;
    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_ready, mem_we, mem_re, busy;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        wr_ready = 1'b1;
    logic        hold_low = 1'b0;

    assign mem_ready = wr_ready && !hold_low;

    always #5 clk = ~clk;

    fram_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_re(mem_re), .busy(busy)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    endtask

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    // FRAM wrapper: drops ready the cycle after a strobe, returns 1..4 cycles later.
    logic [31:0] mem [256];
    initial begin : wrapper
        logic        seen;
        logic [31:0] pend;
        int          left;
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
        left = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            seen = rst_n && (mem_we || mem_re);
            if (seen) begin
                if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
                pend = mem[mem_addr[7:0]];
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wr_ready = 1'b1;
                left = 0;
            end else if (seen) begin
                wr_ready = 1'b0;
                mem_rdata = $urandom;
                left = $urandom_range(1, 4);
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    wr_ready = 1'b1;
                    mem_rdata = pend;
                end
            end
        end
    end

    // Transaction model: cycle indices of strobe (m_g) and ack (m_a) per grant.
    int          md_cyc = 0, m_g = 0, m_a = -1;
    bit          m_act = 0, m_gid = 0, m_low = 0, m_we = 0, m_err = 0, m_prio = 0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
    bit          e_busy = 0, e_we = 0, e_re = 0, e_ack0 = 0, e_ack1 = 0;

    initial begin : model
        int n;
        forever begin
            @(posedge clk or negedge rst_n);
            md_cyc++;
            if (!rst_n) begin
                m_act = 0; m_prio = 0; m_a = -1; m_g = 0; m_gid = 0; m_low = 0;
                m_we = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
            end else if (m_act && m_a >= 0 && md_cyc == m_a + 1) begin
                m_act = 0;
            end else if (!m_act) begin
                if (mem_ready && (m0_req || m1_req)) begin
                    m_gid   = (m0_req && m1_req) ? m_prio : m1_req;
                    m_we    = m_gid ? m1_we : m0_we;
                    m_addr  = m_gid ? m1_addr : m0_addr;
                    m_wdata = m_gid ? m1_wdata : m0_wdata;
                    m_act = 1; m_g = md_cyc; m_a = -1; m_low = 0;
                end
            end else if (m_a < 0 && md_cyc - 1 >= m_g + 1) begin
                n = md_cyc - 2 - m_g;
                if (mem_ready && m_low) begin
                    m_a = md_cyc; m_err = 0; m_prio = !m_gid;
                    if (!m_we && m_gid) m_rd1 = mem_rdata;
                    if (!m_we && !m_gid) m_rd0 = mem_rdata;
                end else if (n == int'(T) - 1) begin
                    m_a = md_cyc; m_err = 1; m_prio = !m_gid;
                end
                if (!mem_ready) m_low = 1;
            end
            e_busy = m_act;
            e_we   = m_act && md_cyc == m_g && m_we;
            e_re   = m_act && md_cyc == m_g && !m_we;
            e_ack0 = m_act && md_cyc == m_a && !m_gid;
            e_ack1 = m_act && md_cyc == m_a && m_gid;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("busy_strobe", 128'({busy, mem_we, mem_re}), 128'({e_busy, e_we, e_re}));
            check("ack_err", 128'({m0_ack, m0_err, m1_ack, m1_err}),
                  128'({e_ack0, e_ack0 && m_err, e_ack1, e_ack1 && m_err}));
            check("addr_wdata", 128'({mem_addr, mem_wdata}), 128'({m_addr, m_wdata}));
            check("rdata", 128'({m0_rdata, m1_rdata}), 128'({m_rd0, m_rd1}));
        end
    end

    int          we_cnt = 0, re_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    int          last_strobe = 0, last_ack0 = 0, last_ack1 = 0, min_gap1 = 1000;
    logic [15:0] addr_log [$];

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (mem_we || mem_re) begin
                last_strobe = tcyc;
                addr_log.push_back(mem_addr);
            end
            if (m0_ack) begin
                ack0_cnt++;
                last_ack0 = tcyc;
            end
            if (m1_ack) begin
                if (tcyc - last_ack1 < min_gap1) min_gap1 = tcyc - last_ack1;
                ack1_cnt++;
                last_ack1 = tcyc;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic txn(input bit id, input logic we, input logic [15:0] a, input logic [31:0] d,
                       input bit hold, output logic err, output logic [31:0] rd);
        int n;
        if (id) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        else begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
        n = 0; err = 0; rd = '0;
        forever begin
            @(negedge clk);
            n++;
            if (id ? m1_ack : m0_ack) begin
                err = id ? m1_err : m0_err;
                rd  = id ? m1_rdata : m0_rdata;
                break;
            end
            if (n >= 300) begin
                checks++;
                $display("FAIL ack_wait m%0d: no ack within %0d cycles, required one", id, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (id) m1_req = 0;
            else m0_req = 0;
        end
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_we || mem_re) && n < 50);
        if (!(mem_we || mem_re)) begin
            checks++;
            $display("FAIL strobe_wait: no strobe within %0d cycles, required one", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_master(input bit id, input int cnt);
        logic        e;
        logic [31:0] r;
        int          gap;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < cnt; i++) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            gap = $urandom_range(0, 3);
            txn(id, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), $urandom,
                (gap == 0 && i != cnt - 1), e, r);
        end
    endtask

    initial begin : main
        logic        e0, e1;
        logic [31:0] r0, r1;
        int          w0, q0, a0, b1, rel, s0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              128'({busy, mem_we, mem_re, m0_ack, m1_ack, m0_err, m1_err, mem_addr, mem_wdata}),
              128'(0));
        check("reset_rdata", 128'({m0_rdata, m1_rdata}), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;

        // Simultaneous requests: m0 first after reset, then m1, then m0 again.
        addr_log.delete();
        fork
            txn(0, 1, 16'h0020, 32'h1111_2222, 0, e0, r0);
            txn(1, 1, 16'h0030, 32'h3333_4444, 0, e1, r1);
        join
        fork
            txn(0, 0, 16'h0030, 32'h0, 0, e0, r0);
            txn(1, 0, 16'h0020, 32'h0, 0, e1, r1);
        join
        check("rr_order", 128'({addr_log[0], addr_log[1], addr_log[2], addr_log[3]}),
              128'({16'h0020, 16'h0030, 16'h0030, 16'h0020}));
        check("rr_rdata", 128'({r0, r1, e0, e1}), 128'({32'h3333_4444, 32'h1111_2222, 2'b00}));

        // Write then read back.
        w0 = we_cnt; q0 = re_cnt; a0 = ack0_cnt;
        txn(0, 1, 16'h0010, 32'hDEAD_BEEF, 0, e0, r0);
        check("wr_strobes", 128'({32'(we_cnt - w0), 32'(re_cnt - q0), e0}), 128'({32'd1, 32'd0, 1'b0}));
        txn(0, 0, 16'h0010, 32'h0, 0, e0, r0);
        check("rd_strobes", 128'({32'(we_cnt - w0), 32'(re_cnt - q0)}), 128'({32'd1, 32'd1}));
        check("rd_data", 128'({r0, e0, 32'(ack0_cnt - a0)}), 128'({32'hDEAD_BEEF, 1'b0, 32'd2}));

        // m1 alone, back-to-back with req held through ack.
        a0 = ack0_cnt; b1 = ack1_cnt; min_gap1 = 1000;
        for (int i = 0; i < 3; i++) begin
            txn(1, 0, 16'(16'h0040 + i), 32'h0, (i < 2), e1, r1);
            check("m1_seq_data", 128'({r1, e1}), 128'({16'hC0DE, 16'(16'h0040 + i), 1'b0}));
        end
        check("m1_seq_acks", 128'({32'(ack1_cnt - b1), 32'(ack0_cnt - a0)}), 128'({32'd3, 32'd0}));
        check("m1_seq_gap", 128'(min_gap1 >= 4), 128'(1));

        // Wrapper never completes: error ack after T wait cycles, rdata untouched.
        fork
            txn(0, 0, 16'h0011, 32'h0, 0, e0, r0);
            begin
                wait_strobe();
                hold_low = 1;
            end
        join
        hold_low = 0;
        check("timeout_ack", 128'({r0, e0}), 128'({32'hDEAD_BEEF, 1'b1}));
        check("timeout_latency", 128'(last_ack0 - last_strobe), 128'(T + 1));
        txn(0, 0, 16'h0010, 32'h0, 0, e0, r0);
        check("after_timeout", 128'({r0, e0}), 128'({32'hDEAD_BEEF, 1'b0}));

        // Reset in the middle of a wait.
        txn(1, 1, 16'h0004, 32'h0BAD_F00D, 0, e1, r1);
        a0 = ack0_cnt;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0010;
        wait_strobe();
        hold_low = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 0;
        m0_req = 0;
        #1;
        check("mid_reset_outputs",
              128'({busy, mem_we, mem_re, m0_ack, m1_ack, m0_err, m1_err, mem_addr, m0_rdata, m1_rdata}),
              128'(0));
        hold_low = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk);
        #1;
        check("mid_reset_no_ack", 128'(ack0_cnt - a0), 128'(0));
        txn(1, 0, 16'h0004, 32'h0, 0, e1, r1);
        check("post_reset_read", 128'({r1, e1}), 128'({32'h0BAD_F00D, 1'b0}));

        // Wrapper not ready while idle: no grant until ready, strobe the next cycle.
        s0 = we_cnt + re_cnt;
        hold_low = 1;
        rel = 0;
        fork
            txn(0, 0, 16'h0030, 32'h0, 0, e0, r0);
            begin
                repeat (5) @(posedge clk);
                #1;
                check("idle_not_ready", 128'(we_cnt + re_cnt - s0), 128'(0));
                rel = tcyc;
                hold_low = 0;
            end
        join
        check("strobe_after_ready", 128'(last_strobe), 128'(rel + 1));
        check("not_ready_data", 128'({r0, e0}), 128'({32'h3333_4444, 1'b0}));

        // Random traffic from both masters with occasional ready glitches.
        fork
            rnd_master(0, 40);
            rnd_master(1, 40);
            begin
                repeat (800) begin
                    @(posedge clk);
                    #1;
                    hold_low = ($urandom_range(0, 9) == 0);
                end
                hold_low = 0;
            end
        join

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, %0d/%0d checks passed so far",
                 passes, checks);
        $fatal(1);
    end

endmodule
